fx3_stream_writer: RTL and testbench

FX3_STREAM_WRITER -- requirements
Module: fx3_stream_writer

---
 rtl/fx3_stream_writer.sv | 105 ++++++++++
 tb/tb_fx3_stream_writer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_stream_writer.sv
// Streams PACKET_WORDS-word packets from the sample FIFO onto the FX3 GPIF bus.
// Write strobe is the read request delayed by READ_LATENCY; packets are never split once started.
module fx3_stream_writer #(
  parameter int PACKET_WORDS = 8192,
  parameter int READ_LATENCY = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        fx3Clk,
  input  logic        nReset,
  input  logic        collectData,
  input  logic        dataAvailable,
  input  logic [15:0] fifoData,
  input  logic        fx3Ready,
  output logic        readData,
  output logic [15:0] fx3Data,
  output logic        fx3nWrite,
  output logic        transferActive,
  output logic [15:0] packetCount
);

  localparam int CW = $clog2(PACKET_WORDS + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, GAP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           word_q, word_d;
  logic [3:0]              gap_q, gap_d;
  logic [READ_LATENCY-1:0] strobe_q, strobe_d;
  logic [15:0]             count_q, count_d;
  logic                    armed_q;

  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      gap_q    <= '0;
      strobe_q <= '0;
      count_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      gap_q    <= gap_d;
      strobe_q <= strobe_d;
      count_q  <= count_d;
      armed_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    gap_d       = gap_q;
    count_d     = count_q;
    strobe_d    = '0;
    strobe_d[0] = (state_q == READ);
    for (int k = 1; k < READ_LATENCY; k++) begin
      strobe_d[k] = strobe_q[k-1];
    end

    case (state_q)
      IDLE: begin
        // armed_q holds off the first packet until one full cycle after reset release
        if (armed_q && collectData && dataAvailable && fx3Ready) begin
          state_d = READ;
          word_d  = '0;
        end
      end
      READ: begin
        if (word_q == CW'(PACKET_WORDS - 1)) begin
          state_d = DRAIN;
          word_d  = '0;
        end else begin
          word_d = word_q + CW'(1);
        end
      end
      DRAIN: begin
        if (strobe_d == '0) begin
          state_d = GAP;
          gap_d   = '0;
          count_d = count_q + 16'd1;
        end
      end
      GAP: begin
        if (gap_q == 4'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == IDLE || state_q == GAP) && !collectData) begin
      count_d = '0;
    end
  end

  assign readData       = (state_q == READ);
  assign fx3nWrite      = ~strobe_q[READ_LATENCY-1];
  assign transferActive = readData | (|strobe_q);
  assign fx3Data        = fifoData;
  assign packetCount    = count_q;

endmodule

// File: tb/tb_fx3_stream_writer.sv
// Bench for fx3_stream_writer: directed packet scenarios on a default instance, random
// flag traffic on a small instance, both scored against a packet-timeline reference model.
module tb_fx3_stream_writer;

  logic        fx3Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        col0 = 1'b0, da0 = 1'b0, rdy0 = 1'b0;
  logic        col1 = 1'b0, da1 = 1'b0, rdy1 = 1'b0;
  logic [15:0] fifoData0 = '0, fifoData1 = '0;
  logic        readData0, fx3nWrite0, ta0, readData1, fx3nWrite1, ta1;
  logic [15:0] fx3Data0, pc0, fx3Data1, pc1;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  always #5 fx3Clk = ~fx3Clk;

  fx3_stream_writer dut0 (
    .fx3Clk(fx3Clk), .nReset(nReset), .collectData(col0), .dataAvailable(da0),
    .fifoData(fifoData0), .fx3Ready(rdy0), .readData(readData0), .fx3Data(fx3Data0),
    .fx3nWrite(fx3nWrite0), .transferActive(ta0), .packetCount(pc0)
  );

  fx3_stream_writer #(.PACKET_WORDS(16), .READ_LATENCY(1), .GAP_CYCLES(3)) dut1 (
    .fx3Clk(fx3Clk), .nReset(nReset), .collectData(col1), .dataAvailable(da1),
    .fifoData(fifoData1), .fx3Ready(rdy1), .readData(readData1), .fx3Data(fx3Data1),
    .fx3nWrite(fx3nWrite1), .transferActive(ta1), .packetCount(pc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // FIFO stand-in: each read returns the next ramp value, READ_LATENCY edges later
  logic [15:0] pipe0 [4];
  logic [15:0] pipe1 [4];
  int rd_idx0 = 0, rd_idx1 = 0;
  always @(posedge fx3Clk) begin
    for (int s = 3; s > 0; s--) begin
      pipe0[s] = pipe0[s-1];
      pipe1[s] = pipe1[s-1];
    end
    pipe0[0] = readData0 ? rd_idx0[15:0] : 16'hBAD0;
    pipe1[0] = readData1 ? rd_idx1[15:0] : 16'hBAD1;
    if (readData0) rd_idx0++;
    if (readData1) rd_idx1++;
    fifoData0 = pipe0[1];
    fifoData1 = pipe1[0];
  end

  // Reference model: each accepted start at cycle c books reads c+1..c+N, writes L later,
  // then G gap cycles before the next start may be considered.
  int pN [2] = '{8192, 16};
  int pL [2] = '{2, 1};
  int pG [2] = '{4, 3};
  int rs [2] = '{-1000000, -1000000};
  int re [2] = '{-2000000, -2000000};
  int nid [2] = '{0, 0};
  int pcx [2] = '{0, 0};
  int ordn [2] = '{0, 0};
  int pbase [2] = '{0, 0};
  int cyc_n [2] = '{0, 0};
  int rel [2] = '{0, 0};
  int pk_done [2] = '{0, 0};

  task automatic model_step(input int i, input logic rstn, input logic col, input logic da,
                            input logic rdy, input logic rd, input logic nw, input logic ta,
                            input logic [15:0] pc, input logic [15:0] dat);
    int  c = cyc_n[i];
    int  n = pN[i];
    int  l = pL[i];
    int  done_rd;
    bit  er, ew, in_pkt;
    if (!rstn) begin
      if (c <= re[i]) begin
        done_rd = c - rs[i];
        if (done_rd < 0) done_rd = 0;
        if (done_rd > n) done_rd = n;
        ordn[i] = pbase[i] + done_rd;
      end
      rs[i] = -1000000; re[i] = -2000000; nid[i] = 0; pcx[i] = 0; rel[i] = 0;
    end else begin
      rel[i]++;
    end
    er     = (c >= rs[i]) && (c <= re[i]);
    ew     = (c >= rs[i] + l) && (c <= re[i] + l);
    in_pkt = (c >= rs[i]) && (c <= re[i] + l);
    check($sformatf("d%0d_readData", i), 32'(rd), 32'(er));
    check($sformatf("d%0d_fx3nWrite", i), 32'(nw), 32'(!ew));
    check($sformatf("d%0d_transferActive", i), 32'(ta), 32'(in_pkt));
    check($sformatf("d%0d_packetCount", i), 32'(pc), pcx[i] & 32'hFFFF);
    if (ew) check($sformatf("d%0d_fx3Data", i), 32'(dat), (pbase[i] + c - l - rs[i]) & 32'hFFFF);
    if (rstn) begin
      if (c == re[i] + l) begin
        pcx[i] = (pcx[i] + 1) & 32'hFFFF;
        pk_done[i]++;
      end else if (!in_pkt && !col) begin
        pcx[i] = 0;
      end
      if (!in_pkt && c >= nid[i] && rel[i] >= 2 && col && da && rdy) begin
        rs[i] = c + 1;
        re[i] = c + n;
        nid[i] = c + n + l + pG[i] + 1;
        pbase[i] = ordn[i];
        ordn[i] += n;
      end
    end
    cyc_n[i]++;
  endtask

  always @(negedge fx3Clk)
    model_step(0, nReset, col0, da0, rdy0, readData0, fx3nWrite0, ta0, pc0, fx3Data0);
  always @(negedge fx3Clk)
    model_step(1, nReset, col1, da1, rdy1, readData1, fx3nWrite1, ta1, pc1, fx3Data1);

  // Strobe / gap bookkeeping for the directed scenarios
  int nw_total = 0, rd_total = 0, hi_run = 0, last_gap = 0;
  bit seen_low = 1'b0;
  always @(negedge fx3Clk) begin
    if (readData0) rd_total++;
    if (fx3nWrite0) begin
      hi_run++;
    end else begin
      nw_total++;
      if (seen_low && hi_run > 0) last_gap = hi_run;
      hi_run = 0;
      seen_low = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge fx3Clk);
    #1;
  endtask

  task automatic wait_ta(input logic lvl, input int budget, input string tag);
    for (int k = 0; k < budget && ta0 !== lvl; k++) @(negedge fx3Clk);
    check(tag, 32'(ta0), 32'(lvl));
  endtask

  task automatic wait_strobes(input int base, input int n, input int budget, input string tag);
    for (int k = 0; k < budget && (nw_total - base) < n; k++) @(negedge fx3Clk);
    check(tag, nw_total - base, n);
  endtask

  // Random flag traffic for the small instance
  initial begin
    while (!done) begin
      @(posedge fx3Clk);
      #1;
      col1 = ($urandom_range(0, 15) != 0);
      da1  = ($urandom_range(0, 3) != 0);
      rdy1 = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int base, r0, n0;
    cyc(3);
    check("rst_readData", 32'(readData0), 0);
    check("rst_fx3nWrite", 32'(fx3nWrite0), 1);
    check("rst_transferActive", 32'(ta0), 0);
    check("rst_packetCount", 32'(pc0), 0);

    // Single packet, all flags high at reset release
    col0 = 1; da0 = 1; rdy0 = 1; nReset = 1;
    base = nw_total;
    cyc(1);
    check("start_edge1", 32'(readData0), 0);
    cyc(1);
    check("start_edge2", 32'(readData0), 1);
    da0 = 0;
    wait_ta(0, 9000, "pkt1_end");
    check("pkt1_strobes", nw_total - base, 8192);
    check("pkt1_count", 32'(pc0), 1);

    // FX3 not ready
    cyc(20);
    da0 = 1; rdy0 = 0;
    r0 = rd_total; n0 = nw_total;
    cyc(100);
    check("nr_reads", rd_total - r0, 0);
    check("nr_writes", nw_total - n0, 0);
    check("nr_count", 32'(pc0), 1);
    rdy0 = 1;
    cyc(1);
    check("nr_start", 32'(readData0), 1);

    // Flags dropped mid-packet
    base = nw_total;
    wait_strobes(base, 4000, 5000, "mid_word4000");
    @(posedge fx3Clk); #1;
    rdy0 = 0; col0 = 0; da0 = 0;
    wait_ta(0, 9000, "mid_end");
    check("mid_strobes", nw_total - base, 8192);
    cyc(12);
    check("mid_count", 32'(pc0), 0);
    check("mid_idle", 32'(ta0), 0);

    // Back-to-back packets
    base = nw_total;
    col0 = 1; da0 = 1; rdy0 = 1;
    wait_ta(1, 100, "b2b_s1");
    wait_ta(0, 9000, "b2b_e1");
    wait_ta(1, 100, "b2b_s2");
    wait_ta(0, 9000, "b2b_e2");
    wait_ta(1, 100, "b2b_s3");
    @(posedge fx3Clk); #1;
    da0 = 0;
    wait_ta(0, 9000, "b2b_e3");
    check("b2b_strobes", nw_total - base, 3 * 8192);
    check("b2b_gap", last_gap, 2 + 4 + 1);
    check("b2b_count", 32'(pc0), 3);

    // Reset at word 100
    cyc(10);
    da0 = 1;
    base = nw_total;
    wait_strobes(base, 100, 200, "rst_word100");
    @(posedge fx3Clk); #1;
    nReset = 0;
    #1;
    check("mrst_readData", 32'(readData0), 0);
    check("mrst_fx3nWrite", 32'(fx3nWrite0), 1);
    check("mrst_transferActive", 32'(ta0), 0);
    check("mrst_packetCount", 32'(pc0), 0);
    cyc(3);
    nReset = 1;
    base = nw_total;
    wait_ta(1, 20, "mrst_restart");
    @(posedge fx3Clk); #1;
    da0 = 0;
    wait_ta(0, 9000, "mrst_end");
    check("mrst_strobes", nw_total - base, 8192);
    check("mrst_count", 32'(pc0), 1);

    done = 1;
    cyc(3);
    check("d1_packets_seen", 32'(pk_done[1] > 20), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
